// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_pkg
// Brief   : Shared types and defaults for the instruction fetch unit.
// Revision: 1.0
// ============================================================================
package fetch_pkg;

    localparam int FETCH_PC_W   = 10;
    localparam int FETCH_INST_W = 9;
    localparam int JT_DEPTH     = 32;
    localparam int JT_IDX_W     = 5;
    localparam int CNT_W        = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;

    // Jump table contents: entry i targets address 25*(i+1).
    function automatic int jt_entry(input int idx);
        return (idx + 1) * 25;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jump_lut.sv
`default_nettype none
// ============================================================================
// Module  : jump_lut
// Brief   : Constant 32-entry jump table with combinational lookup.
// Revision: 1.0
// ============================================================================
module jump_lut
    import fetch_pkg::*;
#(
    parameter int PC_W = FETCH_PC_W
) (
    input  logic [JT_IDX_W-1:0] idx,
    output logic [PC_W-1:0]     target
);

    logic [PC_W-1:0] table_w [JT_DEPTH];

    for (genvar i = 0; i < JT_DEPTH; i++) begin : g_entry
        assign table_w[i] = PC_W'(jt_entry(i));
    end

    assign target = table_w[idx];

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module  : inst_fetch
// Brief   : PC sequencer with branch/jump/stall/halt control and run counter.
// Revision: 1.0
// ============================================================================
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int PC_W   = FETCH_PC_W,
    parameter int INST_W = FETCH_INST_W
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                start,
    input  logic [PC_W-1:0]     start_addr,
    input  logic                stall,
    input  logic                branch_en,
    input  logic                jump_en,
    input  logic [JT_IDX_W-1:0] offset,
    input  logic                halt_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [INST_W-1:0]   imem_data,
    output logic [INST_W-1:0]   inst,
    output logic                inst_valid,
    output logic                done,
    output logic [CNT_W-1:0]    cycle_count
);

    fetch_state_e      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PC_W-1:0]   w_jt_target;
    logic [PC_W-1:0]   w_branch_ext;

    jump_lut #(
        .PC_W (PC_W)
    ) u_jump_lut (
        .idx    (offset),
        .target (w_jt_target)
    );

    assign w_branch_ext = {{(PC_W-JT_IDX_W){offset[JT_IDX_W-1]}}, offset};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = start_addr;
                    count_d = '0;
                end
            end
            ST_RUN: begin
                // Counts every RUN cycle, including stalls and the halting one.
                if (count_q != {CNT_W{1'b1}}) begin
                    count_d = count_q + CNT_W'(1);
                end
                // A stalled cycle drops any redirect or halt presented with it.
                if (!stall) begin
                    if (halt_req) begin
                        state_d = ST_DONE;
                    end else if (jump_en) begin
                        pc_d = w_jt_target;
                    end else if (branch_en) begin
                        pc_d = pc_q + w_branch_ext;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign inst_valid  = (state_q == ST_RUN);
    assign inst        = (state_q == ST_RUN) ? imem_data : '0;
    assign done        = (state_q == ST_DONE);
    assign cycle_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_inst_fetch
// Brief   : Directed vector bench for inst_fetch with a synthetic memory.
// Revision: 1.0
// ============================================================================
module tb_inst_fetch;

    logic        CLK = 1'b0;
    logic        reset, start, stall, branch_en, jump_en, halt_req;
    logic [9:0]  start_addr;
    logic [4:0]  offset;
    logic [9:0]  imem_addr;
    logic [8:0]  imem_data;
    logic [8:0]  inst;
    logic        inst_valid, done;
    logic [15:0] cycle_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic        st;
        logic [9:0]  addr;
        logic        stl;
        logic        br;
        logic        jmp;
        logic [4:0]  off;
        logic        hlt;
        logic [9:0]  e_pc;
        logic        e_valid;
        logic        e_done;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    always #5 CLK = ~CLK;

    function automatic logic [8:0] mem_word(input logic [9:0] a);
        return a[8:0] ^ 9'h155;
    endfunction

    assign imem_data = mem_word(imem_addr);

    inst_fetch #(.PC_W(10), .INST_W(9)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .start       (start),
        .start_addr  (start_addr),
        .stall       (stall),
        .branch_en   (branch_en),
        .jump_en     (jump_en),
        .offset      (offset),
        .halt_req    (halt_req),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .done        (done),
        .cycle_count (cycle_count)
    );

    function automatic vec_t mkv(input logic rst, input logic st, input int addr,
                                 input logic stl, input logic br, input logic jmp,
                                 input int off, input logic hlt, input int e_pc,
                                 input logic e_valid, input logic e_done, input int e_cnt);
        vec_t v;
        v.rst = rst; v.st = st; v.addr = 10'(addr); v.stl = stl;
        v.br = br; v.jmp = jmp; v.off = 5'(off); v.hlt = hlt;
        v.e_pc = 10'(e_pc); v.e_valid = e_valid; v.e_done = e_done; v.e_cnt = 16'(e_cnt);
        return v;
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        logic [8:0] e_inst;
        reset = v.rst; start = v.st; start_addr = v.addr; stall = v.stl;
        branch_en = v.br; jump_en = v.jmp; offset = v.off; halt_req = v.hlt;
        @(posedge CLK);
        #1;
        e_inst = v.e_valid ? mem_word(v.e_pc) : 9'h000;
        check("pc",    idx, int'(imem_addr),   int'(v.e_pc));
        check("inst",  idx, int'(inst),        int'(e_inst));
        check("valid", idx, int'(inst_valid),  int'(v.e_valid));
        check("done",  idx, int'(done),        int'(v.e_done));
        check("count", idx, int'(cycle_count), int'(v.e_cnt));
    endtask

    initial begin
        //                 rst st addr stl br jmp off hlt  pc  val dn cnt
        vecs.push_back(mkv(1, 0,   0, 0, 0, 0,  0, 0,    0, 0, 0, 0));
        vecs.push_back(mkv(0, 1,   5, 0, 0, 0,  0, 0,    5, 1, 0, 0));
        vecs.push_back(mkv(0, 0,   0, 0, 0, 0,  0, 0,    6, 1, 0, 1));
        vecs.push_back(mkv(0, 0,   0, 0, 0, 0,  0, 0,    7, 1, 0, 2));
        vecs.push_back(mkv(0, 0,   0, 0, 0, 0,  0, 0,    8, 1, 0, 3));
        vecs.push_back(mkv(0, 1,  20, 0, 0, 0,  0, 0,    9, 1, 0, 4));
        vecs.push_back(mkv(0, 0,   0, 0, 0, 0,  0, 1,    9, 0, 1, 5));
        vecs.push_back(mkv(0, 0,   0, 0, 0, 0,  0, 0,    9, 0, 1, 5));
        vecs.push_back(mkv(0, 1,  20, 0, 0, 0,  0, 0,   20, 1, 0, 0));
        vecs.push_back(mkv(0, 0,   0, 0, 1, 0, 28, 0,   16, 1, 0, 1));
        vecs.push_back(mkv(0, 0,   0, 0, 1, 0,  4, 0,   20, 1, 0, 2));
        vecs.push_back(mkv(0, 0,   0, 0, 1, 0,  0, 0,   20, 1, 0, 3));
        vecs.push_back(mkv(0, 0,   0, 0, 1, 1,  3, 0,  100, 1, 0, 4));
        vecs.push_back(mkv(0, 0,   0, 0, 0, 1,  0, 0,   25, 1, 0, 5));
        vecs.push_back(mkv(0, 0,   0, 1, 1, 0,  5, 0,   25, 1, 0, 6));
        vecs.push_back(mkv(0, 0,   0, 1, 0, 1,  7, 0,   25, 1, 0, 7));
        vecs.push_back(mkv(0, 0,   0, 0, 0, 0,  0, 0,   26, 1, 0, 8));
        vecs.push_back(mkv(0, 0,   0, 0, 1, 0, 16, 0,   10, 1, 0, 9));
        vecs.push_back(mkv(0, 0,   0, 0, 1, 0, 16, 0, 1018, 1, 0, 10));
        vecs.push_back(mkv(0, 0,   0, 1, 0, 0,  0, 1, 1018, 1, 0, 11));
        vecs.push_back(mkv(0, 0,   0, 0, 0, 1,  2, 1, 1018, 0, 1, 12));
        vecs.push_back(mkv(0, 1, 1023, 0, 0, 0, 0, 0, 1023, 1, 0, 0));
        vecs.push_back(mkv(0, 0,   0, 0, 0, 0,  0, 0,    0, 1, 0, 1));
        vecs.push_back(mkv(0, 0,   0, 1, 0, 0,  0, 0,    0, 1, 0, 2));
        vecs.push_back(mkv(0, 0,   0, 1, 0, 0,  0, 0,    0, 1, 0, 3));
        vecs.push_back(mkv(0, 0,   0, 0, 0, 0,  0, 0,    1, 1, 0, 4));
        vecs.push_back(mkv(0, 0,   0, 0, 0, 1, 31, 0,  800, 1, 0, 5));
        vecs.push_back(mkv(0, 0,   0, 0, 0, 0,  0, 0,  801, 1, 0, 6));
        vecs.push_back(mkv(1, 1,  12, 0, 0, 0,  0, 0,    0, 0, 0, 0));
        vecs.push_back(mkv(0, 1,  12, 0, 0, 0,  0, 0,   12, 1, 0, 0));
        vecs.push_back(mkv(1, 1,   7, 0, 1, 0,  3, 0,    0, 0, 0, 0));
        vecs.push_back(mkv(0, 0,   0, 0, 0, 0,  0, 0,    0, 0, 0, 0));
        vecs.push_back(mkv(0, 0,   0, 0, 1, 1,  3, 1,    0, 0, 0, 0));
        vecs.push_back(mkv(0, 1,  40, 0, 0, 0,  0, 0,   40, 1, 0, 0));
        vecs.push_back(mkv(0, 0,   0, 0, 0, 0,  0, 1,   40, 0, 1, 1));
        vecs.push_back(mkv(0, 0,   0, 0, 0, 0,  0, 0,   40, 0, 1, 1));
        vecs.push_back(mkv(0, 1,   0, 0, 0, 0,  0, 0,    0, 1, 0, 0));
        vecs.push_back(mkv(0, 0,   0, 0, 0, 0,  0, 1,    0, 0, 1, 1));
        vecs.push_back(mkv(1, 0,   0, 0, 0, 0,  0, 0,    0, 0, 0, 0));

        foreach (vecs[i]) begin
            step(vecs[i], i);
        end

        // Counter saturation: start at 3, stall long enough to pin the counter.
        step(mkv(0, 1, 3, 0, 0, 0, 0, 0, 3, 1, 0, 0), 100);
        reset = 1'b0; start = 1'b0; stall = 1'b1; branch_en = 1'b1;
        jump_en = 1'b0; halt_req = 1'b0; offset = 5'd9;
        for (int n = 0; n < 65534; n++) begin
            @(posedge CLK);
        end
        step(mkv(0, 0, 0, 1, 1, 0, 9, 0, 3, 1, 0, 16'hFFFF), 101);
        step(mkv(0, 0, 0, 1, 0, 0, 0, 0, 3, 1, 0, 16'hFFFF), 102);
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 16'hFFFF), 103);
        step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 1, 16'hFFFF), 104);
        step(mkv(0, 0, 0, 0, 1, 0, 1, 0, 4, 0, 1, 16'hFFFF), 105);
        step(mkv(0, 1, 9, 0, 0, 0, 0, 0, 9, 1, 0, 0), 106);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter PC_W, default 10, program counter width in bits.
REQ-002 Parameter INST_W, default 9, instruction width in bits.
REQ-003 Port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  one-cycle pulse that begins execution at start_addr.
REQ-006 Port start_addr  input  PC_W  first instruction address.
REQ-007 Port stall  input  1  hold PC and instruction for the current cycle.
REQ-008 Port branch_en  input  1  taken branch, PC-relative.
REQ-009 Port jump_en  input  1  absolute jump through the jump table.
REQ-010 Port offset  input  5  branch offset (signed, two's complement) or jump-table index.
REQ-011 Port halt_req  input  1  halt instruction decoded.
REQ-012 Port imem_addr  output  PC_W  instruction memory address (equals PC).
REQ-013 Port imem_data  input  INST_W  combinational instruction memory read data.
REQ-014 Port inst  output  INST_W  instruction presented to the decoder.
REQ-015 Port inst_valid  output  1  inst is valid this cycle.
REQ-016 Port done  output  1  program halted.
REQ-017 Port cycle_count  output  16  RUN cycles since last start.

Function
REQ-018 FSM states SHALL be IDLE, RUN and DONE.
REQ-019 IDLE -> RUN on start; PC <= start_addr and cycle_count <= 0 on the same edge.
REQ-020 RUN -> DONE when halt_req=1 and stall=0; PC frozen at the halt address.
REQ-021 DONE -> RUN on start (restart semantics as REQ-019); DONE otherwise holds.
REQ-022 start in RUN SHALL be ignored.
REQ-023 inst = imem_data and inst_valid = 1 only in RUN; in IDLE/DONE inst = 0 and inst_valid = 0.
REQ-024 RUN next-PC priority: stall (hold) > halt_req (hold) > jump_en (PC <= jump_table[offset]) > branch_en (PC <= PC + sign-extended offset) > PC + 1.
REQ-025 jump_en and branch_en asserted together: jump wins, branch ignored.
REQ-026 Redirect asserted together with stall is dropped; the source must re-assert it.
REQ-027 PC arithmetic SHALL be modulo 2^PC_W: max+1 wraps to 0; negative branches below 0 wrap.
REQ-028 Branch offset 0 SHALL re-fetch the same address (self-loop legal).
REQ-029 Redirects take effect on the next edge: the instruction at the target is presented the cycle after branch_en/jump_en.
REQ-030 cycle_count increments on every RUN cycle, stalled or not, and saturates at 16'hFFFF.
REQ-031 cycle_count holds its value in DONE and IDLE.
REQ-032 done = 1 only in DONE; registered, asserted the cycle after the halting edge.
REQ-033 Jump table: 32 entries of PC_W bits, constant contents, combinational read.

Reset
REQ-034 reset SHALL force state IDLE, PC = 0, cycle_count = 0, done = 0, inst_valid = 0, inst = 0.
REQ-035 reset mid-RUN or in DONE SHALL abort on that edge with no further PC update.
REQ-036 reset SHALL have priority over start asserted on the same cycle.

Structure
REQ-037 Shared package fetch_pkg: FSM state enum, PC_W and INST_W defaults, JT_DEPTH = 32.
REQ-038 Jump table SHALL be a sub-module jump_lut (5-bit index in, PC_W target out).
REQ-039 Instruction memory is external to inst_fetch.

Verification
REQ-040 reset, then start with start_addr=5 and 3 free-running cycles -> imem_addr 5,6,7; inst_valid=1; cycle_count=3.
REQ-041 PC=20 with branch_en, offset=5'b11100 (-4) -> next PC=16; offset=0 -> PC stays 20.
REQ-042 jump_en=1 and branch_en=1, offset=3, jump_lut[3]=100 -> next PC=100.
REQ-043 PC=1023 with no redirect -> next PC=0; stall held 2 cycles -> PC and inst unchanged, cycle_count +2.
REQ-044 halt_req at PC=40 -> done=1 next cycle, PC frozen at 40, inst_valid=0; start with start_addr=0 -> RUN at PC 0, cycle_count=0.
REQ-045 reset asserted mid-RUN at PC=12 together with start -> IDLE, PC=0, done=0, cycle_count=0.
